// File: rtl/vga_scan_ctrl_if.sv
// rtl/vga_scan_ctrl_if.sv - updater req/gnt handshake between game logic and the VGA scan controller
interface vga_scan_ctrl_if;
  logic upd_req;
  logic upd_gnt;
  logic upd_done;
  logic upd_abort;

  modport master (output upd_req, output upd_done, input upd_gnt, input upd_abort);
  modport slave  (input upd_req, input upd_done, output upd_gnt, output upd_abort);
endinterface

// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - 640x480@60 scan timing plus vertical-blank updater arbiter
// Optional VGA_PREFETCH_EN: coordinates lead sync/blank by one cycle for a sync-RAM renderer.
module vga_scan_ctrl #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       i_clk_25M,
  input  logic       i_rst_n,
  output logic       o_hs,
  output logic       o_vs,
  output logic       o_blank_n,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_frame_start,
  vga_scan_ctrl_if.slave upd
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_BEG   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_WIN_HI = 10'(V_TOTAL - 2);
  localparam logic [9:0] VS_BEG   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_on;
  logic       vs_on;
  logic       active;
  logic       in_window;
  arb_state_t arb_state;

  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_comb begin
    hs_on     = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_on     = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    in_window = (v_cnt >= V_ACT) && (v_cnt <= V_WIN_HI);
  end

  // Coordinates always describe the counter value of the previous cycle.
  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
    end else begin
      o_x           <= h_cnt;
      o_y           <= v_cnt;
      o_frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

`ifdef VGA_PREFETCH_EN
  logic hs_q;
  logic vs_q;
  logic blank_n_q;

  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_q      <= ~SYNC_POL;
      vs_q      <= ~SYNC_POL;
      blank_n_q <= 1'b0;
      o_hs      <= ~SYNC_POL;
      o_vs      <= ~SYNC_POL;
      o_blank_n <= 1'b0;
    end else begin
      hs_q      <= hs_on ? SYNC_POL : ~SYNC_POL;
      vs_q      <= vs_on ? SYNC_POL : ~SYNC_POL;
      blank_n_q <= active;
      o_hs      <= hs_q;
      o_vs      <= vs_q;
      o_blank_n <= blank_n_q;
    end
  end
`else
  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_hs      <= ~SYNC_POL;
      o_vs      <= ~SYNC_POL;
      o_blank_n <= 1'b0;
    end else begin
      o_hs      <= hs_on ? SYNC_POL : ~SYNC_POL;
      o_vs      <= vs_on ? SYNC_POL : ~SYNC_POL;
      o_blank_n <= active;
    end
  end
`endif

  // Done outranks window close, so a release on the last window cycle never aborts.
  always_ff @(posedge i_clk_25M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      arb_state     <= ARB_IDLE;
      upd.upd_gnt   <= 1'b0;
      upd.upd_abort <= 1'b0;
    end else begin
      upd.upd_abort <= 1'b0;
      case (arb_state)
        ARB_IDLE: begin
          if (in_window && upd.upd_req) begin
            arb_state   <= ARB_GRANT;
            upd.upd_gnt <= 1'b1;
          end
        end
        ARB_GRANT: begin
          if (upd.upd_done) begin
            arb_state   <= ARB_IDLE;
            upd.upd_gnt <= 1'b0;
          end else if (!in_window) begin
            arb_state     <= ARB_IDLE;
            upd.upd_gnt   <= 1'b0;
            upd.upd_abort <= 1'b1;
          end
        end
        default: begin
          arb_state   <= ARB_IDLE;
          upd.upd_gnt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - self-checking bench for vga_scan_ctrl on a shrunken raster
module tb_vga_scan_ctrl;

  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HSY = 4;
  localparam int HB  = 3;
  localparam int VA  = 12;
  localparam int VF  = 2;
  localparam int VSY = 2;
  localparam int VB  = 3;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VT  = VA + VF + VSY + VB;
  localparam int FR  = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs;
  logic       vs;
  logic       blank_n;
  logic       frame_start;
  logic [9:0] x;
  logic [9:0] y;

  vga_scan_ctrl_if upd_bus();

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .i_clk_25M    (clk),
    .i_rst_n      (rst_n),
    .o_hs         (hs),
    .o_vs         (vs),
    .o_blank_n    (blank_n),
    .o_x          (x),
    .o_y          (y),
    .o_frame_start(frame_start),
    .upd          (upd_bus)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int printed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: k = clock edges since reset release; raster pixel index derived arithmetically.
  int k = 0;
  bit m_gnt = 1'b0;
  bit m_abort = 1'b0;
  int q, p, pv, ex, ey, vx, vy;
  bit win, req_s, done_s, e_hs, e_vs, e_blank;

  always @(posedge clk) begin
    if (!rst_n) begin
      k = 0;
      m_gnt = 1'b0;
      m_abort = 1'b0;
    end else begin
      req_s  = upd_bus.upd_req;
      done_s = upd_bus.upd_done;
      q   = k % FR;
      win = (q / HT >= VA) && (q / HT <= VT - 2);
      m_abort = 1'b0;
      if (!m_gnt) begin
        if (win && req_s) m_gnt = 1'b1;
      end else if (done_s) begin
        m_gnt = 1'b0;
      end else if (!win) begin
        m_gnt = 1'b0;
        m_abort = 1'b1;
      end
      k++;
      #1;
      p  = (k - 1) % FR;
      ex = p % HT;
      ey = p / HT;
`ifdef VGA_PREFETCH_EN
      pv = (k >= 2) ? (k - 2) % FR : -1;
`else
      pv = p;
`endif
      if (pv < 0) begin
        e_hs = 1'b1; e_vs = 1'b1; e_blank = 1'b0;
      end else begin
        vx = pv % HT;
        vy = pv / HT;
        e_hs    = !(vx >= HA + HF && vx < HA + HF + HSY);
        e_vs    = !(vy >= VA + VF && vy < VA + VF + VSY);
        e_blank = (vx < HA) && (vy < VA);
      end
      checks++;
      if (x != 10'(ex) || y != 10'(ey) || frame_start != (p == 0) || hs != e_hs || vs != e_vs
          || blank_n != e_blank || upd_bus.upd_gnt != m_gnt || upd_bus.upd_abort != m_abort) begin
        errors++;
        if (printed < 20) begin
          printed++;
          $display("FAIL cycle k=%0d actual x=%0d y=%0d fs=%0b hs=%0b vs=%0b bl=%0b gnt=%0b ab=%0b expected x=%0d y=%0d fs=%0b hs=%0b vs=%0b bl=%0b gnt=%0b ab=%0b",
                   k, x, y, frame_start, hs, vs, blank_n, upd_bus.upd_gnt, upd_bus.upd_abort,
                   ex, ey, (p == 0), e_hs, e_vs, e_blank, m_gnt, m_abort);
        end
      end
    end
  end

  task automatic wait_px(input int wx, input int wy, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3 * FR; n++) begin
      @(posedge clk); #1;
      if (x == 10'(wx) && y == 10'(wy)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3 * FR; n++) begin
      @(posedge clk); #1;
      if (upd_bus.upd_gnt) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_abort(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3 * FR; n++) begin
      @(posedge clk); #1;
      if (upd_bus.upd_abort) begin ok = 1'b1; break; end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hs"}, hs, 1);
    chk({tag, "_vs"}, vs, 1);
    chk({tag, "_blank"}, blank_n, 0);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_gnt"}, upd_bus.upd_gnt, 0);
    chk({tag, "_abort"}, upd_bus.upd_abort, 0);
  endtask

  int fs_cnt, bl_cnt, hs_lo, vs_lo;
  bit ok;

  initial begin
    upd_bus.upd_req  = 1'b0;
    upd_bus.upd_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");

    @(negedge clk); rst_n = 1'b1;
    fs_cnt = 0; bl_cnt = 0; hs_lo = 0; vs_lo = 0;
    for (int i = 0; i < FR; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        chk("first_x", x, 0);
        chk("first_y", y, 0);
        chk("first_fs", frame_start, 1);
`ifdef VGA_PREFETCH_EN
        chk("first_blank_pf", blank_n, 0);
`else
        chk("first_blank", blank_n, 1);
`endif
      end
`ifdef VGA_PREFETCH_EN
      if (i == 1) begin
        chk("pf_x", x, 1);
        chk("pf_blank", blank_n, 1);
      end
`endif
      fs_cnt += int'(frame_start);
      bl_cnt += int'(blank_n);
      hs_lo  += int'(!hs);
      vs_lo  += int'(!vs);
    end
    chk("frame_starts", fs_cnt, 1);
    chk("blank_count", bl_cnt, HA * VA);
    chk("hs_low_count", hs_lo, HSY * VT);
    chk("vs_low_count", vs_lo, VSY * HT);

    // Request held from mid-frame: grant appears with pixel (0, VA).
    @(negedge clk); upd_bus.upd_req = 1'b1;
    wait_gnt(ok);
    chk("t3_gnt_seen", ok, 1);
    chk("t3_gnt_x", x, 0);
    chk("t3_gnt_y", y, VA);
    wait_px(0, VA + 2, ok);
    chk("t3_reach_y", ok, 1);
    @(negedge clk); upd_bus.upd_done = 1'b1;
    @(posedge clk); #1;
    chk("t3_gnt_drop", upd_bus.upd_gnt, 0);
    @(negedge clk); upd_bus.upd_done = 1'b0;
    @(posedge clk); #1;
    chk("t3_regrant", upd_bus.upd_gnt, 1);
    @(negedge clk); upd_bus.upd_req = 1'b0; upd_bus.upd_done = 1'b1;
    @(negedge clk); upd_bus.upd_done = 1'b0;

    // Request never released: abort on entering the guard line, next grant a frame later.
    wait_px(0, 0, ok);
    chk("t4_reach_y0", ok, 1);
    @(negedge clk); upd_bus.upd_req = 1'b1;
    wait_gnt(ok);
    chk("t4_gnt_seen", ok, 1);
    chk("t4_gnt_y", y, VA);
    wait_abort(ok);
    chk("t4_abort_seen", ok, 1);
    chk("t4_abort_x", x, 0);
    chk("t4_abort_y", y, VT - 1);
    chk("t4_abort_gnt", upd_bus.upd_gnt, 0);
    @(posedge clk); #1;
    chk("t4_abort_pulse", upd_bus.upd_abort, 0);
    wait_gnt(ok);
    chk("t4_regnt_seen", ok, 1);
    chk("t4_regnt_x", x, 0);
    chk("t4_regnt_y", y, VA);

    // Asynchronous reset while granted.
    wait_px(0, VA + 2, ok);
    chk("t5_reach_y", ok, 1);
    chk("t5_gnt_before", upd_bus.upd_gnt, 1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk_reset_vals("t5_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_x", x, 0);
    chk("t5_y", y, 0);
    chk("t5_fs", frame_start, 1);
    chk("t5_gnt", upd_bus.upd_gnt, 0);
    @(negedge clk); upd_bus.upd_req = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
